rand_mask_arbiter: RTL and testbench
====================================

# rand_mask_arbiter

Shares the single `random_mask_gen` instance between several Sudoku-engine requesters, such as the puzzle generator, the cell blanker and the solver. Each requester asks for a one-hot random digit mask over a range of 1..N (N = 2..9). The arbiter grants requesters round-robin, samples the matching generator output and returns one registered mask per transaction with a one-cycle valid pulse. An optional exclusion stage rejects masks that hit digits the requester has already used, with bounded retry and deterministic fallback.

## Interface
- `NUM_REQ`, default 3: number of requesters, 2..8.
- `RETRY_MAX`, default 15: maximum resample cycles per transaction (exclusion build only), 1..255.
- `clk_in`  in  1: system clock.
- `reset_in`  in  1: one clock; reset is synchronous and active-high.
- `masks_in`  in  72: generator outputs; `masks_in[9*(r-2)+:9]` is the one-hot mask for range 1..r, r = 2..9.
- `req_in`  in  NUM_REQ: request per requester, level; held until that requester's `valid_out` bit is seen.
- `range_in`  in  4*NUM_REQ: `range_in[4*i+:4]` is requester i's range r.
- `exclude_in`  in  9*NUM_REQ: `exclude_in[9*i+:9]` is requester i's excluded digits (bit k = digit k+1); ignored without the macro.
- `grant_out`  out  NUM_REQ: one-hot, high while requester i's transaction is in flight.
- `mask_out`  out  9: delivered mask; valid only while `valid_out` is nonzero.
- `valid_out`  out  NUM_REQ: one-cycle one-hot pulse to the served requester.
- `fail_out`  out  1: pulses with `valid_out` when no legal digit exists (`mask_out` = 0).
- `busy_out`  out  1: high in any state other than IDLE.

## Operation
- The FSM has three states: IDLE, SAMPLE and DELIVER.
- Registered state: `ptr` (round-robin start, reset 0), latched index `idx`, latched range `rng`, latched exclude `exc`, and `retry_cnt` (8 bits).
- **IDLE:** if any `req_in` bit is set, pick the first set bit searching from `ptr` upward with wrap.
  - Latch `idx`, `rng` and `exc`; set `grant_out[idx]`; clear `retry_cnt`; go to SAMPLE.
  - Otherwise stay in IDLE.
- **SAMPLE:** compute `cand`.
  - For `rng` in 2..9, `cand = masks_in[9*(rng-2)+:9]`.
  - For an illegal `rng` (0, 1, 10..15), `cand = 9'h001` and it is accepted immediately.
  - Without the macro, `cand` is always accepted: register `mask_out = cand` and `valid_out[idx] = 1`, then go to DELIVER.
- **DELIVER:** clear `valid_out`, `grant_out` and `mask_out`; set `ptr = (idx+1) mod NUM_REQ`; go to IDLE.
- If `req_in[idx]` drops after the grant, the transaction still completes.
- A requester that still holds `req_in` in the IDLE cycle after its valid pulse is arbitrated as a new request.
- Reset mid-transaction: the transaction is abandoned with no valid pulse. The requester keeps `req_in` high and is served after reset.
- Requester index arithmetic wraps modulo `NUM_REQ`; `retry_cnt` saturates at `RETRY_MAX`.

## Timing
- Reset values: state IDLE, `ptr` = 0, `grant_out` = 0, `valid_out` = 0, `mask_out` = 0, `fail_out` = 0, `busy_out` = 0.
- Request first seen at edge E0 (in IDLE):
  - `grant_out` is high after E0.
  - `valid_out`/`mask_out` are high after E1, plus one edge per retry.
  - Everything clears after E2.
  - The next arbitration is at E3 or later.
- Peak throughput is one mask per 3 cycles.
- `masks_in` is sampled at the accepting SAMPLE edge only; the generator runs freely and needs no handshake.
- The served requester must deassert `req_in` in the cycle `valid_out` is high. It must not deassert before grant, or the pending request is dropped silently.

## Configuration
- `RAND_MASK_EXCLUDE_EN` defined:
  - In SAMPLE, if `cand & exc` is nonzero and `retry_cnt < RETRY_MAX`: increment `retry_cnt` and stay in SAMPLE (resample next cycle).
  - If there is no hit: accept `cand`.
  - If there is a hit and `retry_cnt == RETRY_MAX`: deliver the lowest digit k < `rng` whose `exc` bit is clear.
  - If no such digit exists, deliver `mask_out = 0` with `fail_out` = 1.
  - Illegal ranges bypass exclusion.
- `RAND_MASK_EXCLUDE_EN` undefined:
  - `exclude_in` is unused.
  - SAMPLE always takes exactly one cycle.
  - `fail_out` is tied to 0.

## Test plan
- **Single request.** `req_in=001`, `range=9`, slice for r=9 = 9'h010 -> `grant_out=001` after E0; `valid_out=001`, `mask_out=9'h010` after E1; `busy_out=0` after E2.
- **Round-robin.** `req_in=111` held continuously, one valid pulse per requester -> service order 0,1,2,0,1 with valid pulses 3 cycles apart.
- **Illegal range.** `range=0`, then `range=12` -> `mask_out=9'h001`, `fail_out=0`, latency unchanged.
- **Exclusion with fallback.** Macro on, `exclude=9'h1FE`, `range=9`, `masks_in` slice held at 9'h004 -> 15 retry cycles, then `mask_out=9'h001` with `valid_out` after E1+15.
- **Exclusion with no legal digit.** Macro on, `exclude=9'h00F`, `range=4` -> `mask_out=0`, `fail_out=1` pulsed with `valid_out`.
- **Reset mid-SAMPLE.** Assert `reset_in` for one cycle during SAMPLE -> all outputs 0 after that edge, no valid pulse, `ptr=0`; the held request is served 2 edges after reset release.

Source files
------------

// File: rtl/rand_mask_arbiter.sv
// rand_mask_arbiter: round-robin share of one random_mask_gen between
// several requesters. Each transaction returns one registered one-hot
// digit mask with a one-cycle valid pulse to the served requester.
// Optional exclusion/retry stage enabled by defining RAND_MASK_EXCLUDE_EN.
module rand_mask_arbiter #(
    parameter int unsigned NUM_REQ   = 3,
    parameter int unsigned RETRY_MAX = 15
) (
    input  logic                   clk_in,
    input  logic                   reset_in,
    input  logic [71:0]            masks_in,
    input  logic [NUM_REQ-1:0]     req_in,
    input  logic [4*NUM_REQ-1:0]   range_in,
    input  logic [9*NUM_REQ-1:0]   exclude_in,
    output logic [NUM_REQ-1:0]     grant_out,
    output logic [8:0]             mask_out,
    output logic [NUM_REQ-1:0]     valid_out,
    output logic                   fail_out,
    output logic                   busy_out
);

    localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_SAMPLE  = 2'd1;
    localparam logic [1:0] S_DELIVER = 2'd2;

    logic [1:0]         state_q, state_n;
    logic [IDX_W-1:0]   ptr_q, ptr_n;
    logic [IDX_W-1:0]   idx_q, idx_n;
    logic [3:0]         rng_q, rng_n;
    logic [NUM_REQ-1:0] grant_n;
    logic [8:0]         mask_n;
    logic [NUM_REQ-1:0] valid_n;
    logic               busy_n;
    logic [8:0]         cand;
    logic               legal;

`ifdef RAND_MASK_EXCLUDE_EN
    logic [8:0]         exc_q, exc_n;
    logic [7:0]         retry_q, retry_n;
    logic               fail_n;
    logic [8:0]         fb_mask;
    logic               fb_found;
`else
    logic               unused_cfg;
    assign unused_cfg = ^{exclude_in, 32'(RETRY_MAX)};
    assign fail_out   = 1'b0;
`endif

    // Candidate mask for the latched range; illegal ranges map to digit 1
    always_comb begin
        cand  = 9'h001;
        legal = 1'b0;
        for (int r = 2; r <= 9; r++) begin
            if (rng_q == 4'(r)) begin
                cand  = masks_in[9*(r-2) +: 9];
                legal = 1'b1;
            end
        end
    end

`ifdef RAND_MASK_EXCLUDE_EN
    // Deterministic fallback: lowest in-range digit not excluded
    always_comb begin
        fb_mask  = 9'h000;
        fb_found = 1'b0;
        for (int k = 0; k < 9; k++) begin
            if (!fb_found && (4'(k) < rng_q) && !exc_q[k]) begin
                fb_mask[k] = 1'b1;
                fb_found   = 1'b1;
            end
        end
    end
`endif

    // Next-state and next-output logic
    always_comb begin
        int unsigned j;
        logic        found;
        state_n = state_q;
        ptr_n   = ptr_q;
        idx_n   = idx_q;
        rng_n   = rng_q;
        grant_n = grant_out;
        mask_n  = mask_out;
        valid_n = valid_out;
        j       = 0;
        found   = 1'b0;
`ifdef RAND_MASK_EXCLUDE_EN
        exc_n   = exc_q;
        retry_n = retry_q;
        fail_n  = fail_out;
`endif
        case (state_q)
            S_IDLE: begin
                for (int unsigned k = 0; k < NUM_REQ; k++) begin
                    j = (32'(ptr_q) + k) % NUM_REQ;
                    if (!found && req_in[j]) begin
                        found   = 1'b1;
                        idx_n   = IDX_W'(j);
                        rng_n   = range_in[4*j +: 4];
                        grant_n = NUM_REQ'(1) << j;
`ifdef RAND_MASK_EXCLUDE_EN
                        exc_n   = exclude_in[9*j +: 9];
`endif
                    end
                end
                if (found) begin
                    state_n = S_SAMPLE;
`ifdef RAND_MASK_EXCLUDE_EN
                    retry_n = 8'd0;
`endif
                end
            end
            S_SAMPLE: begin
`ifdef RAND_MASK_EXCLUDE_EN
                if (legal && ((cand & exc_q) != 9'h000)) begin
                    if (retry_q < 8'(RETRY_MAX)) begin
                        retry_n = retry_q + 8'd1;
                    end else begin
                        mask_n  = fb_mask;
                        fail_n  = !fb_found;
                        valid_n = NUM_REQ'(1) << idx_q;
                        state_n = S_DELIVER;
                    end
                end else begin
                    mask_n  = cand;
                    fail_n  = 1'b0;
                    valid_n = NUM_REQ'(1) << idx_q;
                    state_n = S_DELIVER;
                end
`else
                mask_n  = legal ? cand : 9'h001;
                valid_n = NUM_REQ'(1) << idx_q;
                state_n = S_DELIVER;
`endif
            end
            S_DELIVER: begin
                grant_n = '0;
                mask_n  = 9'h000;
                valid_n = '0;
`ifdef RAND_MASK_EXCLUDE_EN
                fail_n  = 1'b0;
`endif
                ptr_n   = (idx_q == IDX_W'(NUM_REQ - 1)) ? '0 : idx_q + IDX_W'(1);
                state_n = S_IDLE;
            end
            default: begin
                grant_n = '0;
                mask_n  = 9'h000;
                valid_n = '0;
                state_n = S_IDLE;
            end
        endcase
        busy_n = (state_n != S_IDLE);
    end

    // State and registered outputs
    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            state_q   <= S_IDLE;
            ptr_q     <= '0;
            idx_q     <= '0;
            rng_q     <= 4'd0;
            grant_out <= '0;
            mask_out  <= 9'h000;
            valid_out <= '0;
            busy_out  <= 1'b0;
`ifdef RAND_MASK_EXCLUDE_EN
            exc_q     <= 9'h000;
            retry_q   <= 8'd0;
            fail_out  <= 1'b0;
`endif
        end else begin
            state_q   <= state_n;
            ptr_q     <= ptr_n;
            idx_q     <= idx_n;
            rng_q     <= rng_n;
            grant_out <= grant_n;
            mask_out  <= mask_n;
            valid_out <= valid_n;
            busy_out  <= busy_n;
`ifdef RAND_MASK_EXCLUDE_EN
            exc_q     <= exc_n;
            retry_q   <= retry_n;
            fail_out  <= fail_n;
`endif
        end
    end

endmodule

// File: tb/tb_rand_mask_arbiter.sv
// Self-checking bench for rand_mask_arbiter (NUM_REQ = 3).
module tb_rand_mask_arbiter;

    localparam int unsigned NR = 3;
    localparam logic [71:0] BASE = {8{9'h100}};

    logic            clk_in = 1'b0;
    logic            reset_in;
    logic [71:0]     masks_in;
    logic [NR-1:0]   req_in;
    logic [4*NR-1:0] range_in;
    logic [9*NR-1:0] exclude_in;
    logic [NR-1:0]   grant_out;
    logic [8:0]      mask_out;
    logic [NR-1:0]   valid_out;
    logic            fail_out;
    logic            busy_out;

    int tests    = 0;
    int failures = 0;
    int m_ptr    = 0;

    typedef struct {
        logic [NR-1:0]   req;
        logic [4*NR-1:0] rng;
        logic [71:0]     masks;
        int              exp_idx;
        logic [8:0]      exp_mask;
    } vec_t;

    vec_t vecs [6];

    rand_mask_arbiter #(.NUM_REQ(NR), .RETRY_MAX(15)) dut (
        .clk_in    (clk_in),
        .reset_in  (reset_in),
        .masks_in  (masks_in),
        .req_in    (req_in),
        .range_in  (range_in),
        .exclude_in(exclude_in),
        .grant_out (grant_out),
        .mask_out  (mask_out),
        .valid_out (valid_out),
        .fail_out  (fail_out),
        .busy_out  (busy_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [71:0] set_slice(input logic [71:0] base, input int r, input logic [8:0] m);
        logic [71:0] v;
        v = base;
        v[9*(r-2) +: 9] = m;
        return v;
    endfunction

    // Reference: first requester at or after ptr, wrapping
    function automatic int model_pick(input logic [NR-1:0] req, input int ptr);
        for (int k = 0; k < int'(NR); k++) begin
            if (req[(ptr + k) % NR]) return (ptr + k) % NR;
        end
        return -1;
    endfunction

    // Reference: mask the generator offers for range r
    function automatic logic [8:0] model_mask(input logic [71:0] masks, input int r);
        logic [71:0] sh;
        if (r < 2 || r > 9) return 9'h001;
        sh = masks >> (9 * (r - 2));
        return sh[8:0];
    endfunction

    // One transaction from IDLE; masks switch to masks1 after the grant edge
    task automatic run_txn(input string tag, input logic [NR-1:0] req, input logic [4*NR-1:0] rng,
                           input logic [71:0] masks0, input logic [71:0] masks1,
                           input int exp_idx, input logic [8:0] exp_mask, input bit drop_early);
        logic [NR-1:0] oh;
        oh = NR'(1) << exp_idx;
        req_in   = req;
        range_in = rng;
        masks_in = masks0;
        tick();
        chk({tag, " grant"}, 32'(grant_out), 32'(oh));
        chk({tag, " early_valid"}, 32'(valid_out), 32'd0);
        chk({tag, " busy"}, 32'(busy_out), 32'd1);
        masks_in = masks1;
        if (drop_early) req_in[exp_idx] = 1'b0;
        tick();
        chk({tag, " valid"}, 32'(valid_out), 32'(oh));
        chk({tag, " mask"}, 32'(mask_out), 32'(exp_mask));
        chk({tag, " fail"}, 32'(fail_out), 32'd0);
        req_in = '0;
        tick();
        chk({tag, " clr_valid"}, 32'(valid_out), 32'd0);
        chk({tag, " clr_grant"}, 32'(grant_out), 32'd0);
        chk({tag, " clr_mask"}, 32'(mask_out), 32'd0);
        chk({tag, " idle"}, 32'(busy_out), 32'd0);
        m_ptr = (exp_idx + 1) % NR;
    endtask

    task automatic do_reset();
        reset_in = 1'b1;
        tick();
        tick();
        reset_in = 1'b0;
        m_ptr = 0;
    endtask

    initial begin
        int cyc;
        int w;
        int order [5];
        logic [71:0] m0, m1;
        logic [NR-1:0] rq;
        logic [4*NR-1:0] rg;

        order = '{0, 1, 2, 0, 1};
        vecs[0] = '{3'b001, {4'd0, 4'd0, 4'd9},  set_slice(BASE, 9, 9'h010), 0, 9'h010};
        vecs[1] = '{3'b101, {4'd3, 4'd0, 4'd9},  set_slice(BASE, 3, 9'h004), 2, 9'h004};
        vecs[2] = '{3'b110, {4'd7, 4'd0, 4'd9},  BASE,                        1, 9'h001};
        vecs[3] = '{3'b011, {4'd2, 4'd4, 4'd12}, BASE,                        0, 9'h001};
        vecs[4] = '{3'b001, {4'd9, 4'd9, 4'd2},  set_slice(BASE, 2, 9'h002), 0, 9'h002};
        vecs[5] = '{3'b010, {4'd3, 4'd5, 4'd2},  set_slice(BASE, 5, 9'h010), 1, 9'h010};

        req_in     = '0;
        range_in   = '0;
        masks_in   = BASE;
        exclude_in = '0;
        reset_in   = 1'b1;
        tick();
        tick();
        chk("rst grant", 32'(grant_out), 32'd0);
        chk("rst valid", 32'(valid_out), 32'd0);
        chk("rst mask", 32'(mask_out), 32'd0);
        chk("rst fail", 32'(fail_out), 32'd0);
        chk("rst busy", 32'(busy_out), 32'd0);
        reset_in = 1'b0;
        tick();

        // Directed vectors: single request, wrap search, illegal ranges
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("vec%0d model_idx", i), 32'(model_pick(vecs[i].req, m_ptr)), 32'(vecs[i].exp_idx));
            run_txn($sformatf("vec%0d", i), vecs[i].req, vecs[i].rng, vecs[i].masks, vecs[i].masks,
                    vecs[i].exp_idx, vecs[i].exp_mask, 1'b0);
        end

        // Round-robin with all requests held continuously
        do_reset();
        range_in = {4'd9, 4'd9, 4'd9};
        masks_in = set_slice(BASE, 9, 9'h080);
        req_in   = 3'b111;
        for (int n = 0; n < 5; n++) begin
            cyc = 0;
            do begin
                tick();
                cyc++;
            end while (valid_out == '0 && cyc < 12);
            chk($sformatf("rr%0d valid", n), 32'(valid_out), 32'(NR'(1) << order[n]));
            chk($sformatf("rr%0d gap", n), 32'(cyc), (n == 0) ? 32'd2 : 32'd3);
            chk($sformatf("rr%0d mask", n), 32'(mask_out), 32'h080);
        end
        req_in = '0;
        tick();
        tick();
        chk("rr drained", 32'(busy_out), 32'd0);

        // Reset during SAMPLE: abandoned, ptr back to 0, held request served
        req_in = 3'b100;
        tick();
        chk("rstmid grant", 32'(grant_out), 32'b100);
        reset_in = 1'b1;
        req_in   = 3'b111;
        tick();
        chk("rstmid grant0", 32'(grant_out), 32'd0);
        chk("rstmid valid0", 32'(valid_out), 32'd0);
        chk("rstmid mask0", 32'(mask_out), 32'd0);
        chk("rstmid busy0", 32'(busy_out), 32'd0);
        reset_in = 1'b0;
        tick();
        chk("rstmid regrant", 32'(grant_out), 32'b001);
        tick();
        chk("rstmid valid", 32'(valid_out), 32'b001);
        req_in = '0;
        tick();
        chk("rstmid idle", 32'(busy_out), 32'd0);
        m_ptr = 1;

        // Randomized transactions against the reference model
        for (int t = 0; t < 40; t++) begin
            do rq = NR'($urandom); while (rq == '0);
            for (int i = 0; i < int'(NR); i++) rg[4*i +: 4] = 4'($urandom_range(0, 15));
            m0 = {$urandom, $urandom, $urandom};
            m1 = ($urandom_range(0, 1) == 1) ? {$urandom, $urandom, $urandom} : m0;
`ifndef RAND_MASK_EXCLUDE_EN
            exclude_in = 27'($urandom);
`endif
            w = model_pick(rq, m_ptr);
            run_txn($sformatf("rnd%0d", t), rq, rg, m0, m1, w,
                    model_mask(m1, int'(rg[4*w +: 4])), 1'($urandom_range(0, 1)));
        end

`ifdef RAND_MASK_EXCLUDE_EN
        // Exclusion: fallback after RETRY_MAX resamples, then no legal digit
        do_reset();
        exclude_in = {18'd0, 9'h1FE};
        range_in   = {4'd9, 4'd9, 4'd9};
        masks_in   = set_slice(BASE, 9, 9'h004);
        req_in     = 3'b001;
        tick();
        chk("exc grant", 32'(grant_out), 32'b001);
        cyc = 0;
        do begin
            tick();
            cyc++;
        end while (valid_out == '0 && cyc < 40);
        chk("exc latency", 32'(cyc), 32'd16);
        chk("exc mask", 32'(mask_out), 32'h001);
        chk("exc fail", 32'(fail_out), 32'd0);
        req_in = '0;
        tick();
        exclude_in = {18'd0, 9'h00F};
        range_in   = {4'd4, 4'd4, 4'd4};
        masks_in   = set_slice(BASE, 4, 9'h002);
        req_in     = 3'b010;
        tick();
        cyc = 0;
        do begin
            tick();
            cyc++;
        end while (valid_out == '0 && cyc < 40);
        chk("nolegal valid", 32'(valid_out), 32'b010);
        chk("nolegal mask", 32'(mask_out), 32'd0);
        chk("nolegal fail", 32'(fail_out), 32'd1);
        req_in = '0;
        tick();
        chk("nolegal fail_clr", 32'(fail_out), 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
